// File: rtl/ccc_cfg_seq.sv
// ccc_cfg_seq: CCC divider/bypass reconfiguration sequencer with lock filtering, timeout and lock-loss recovery
module ccc_cfg_seq #(
  parameter int HOLD_CYC     = 8,
  parameter int LOCK_FILT    = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       FAB_CLK,
  input  logic       M2F_RESET_N,
  input  logic       CFG_REQ,
  input  logic [4:0] CFG_OBDIV,
  input  logic [4:0] CFG_OCDIV,
  input  logic       CFG_BYPASSB,
  input  logic       CFG_BYPASSC,
  input  logic       CCC_LOCK,
  output logic       CFG_ACK,
  output logic [4:0] OBDIV,
  output logic [4:0] OCDIV,
  output logic       BYPASSB,
  output logic       BYPASSC,
  output logic       CLKRST_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);
  typedef enum logic [2:0] {IDLE, HOLD, APPLY, WAIT_LOCK, RELEASE} state_t;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  FILT_LAST = 8'(LOCK_FILT - 1);
  localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  state_t      state;
  logic [1:0]  sync;
  logic        slock, low_prev, lock_watch;
  logic [7:0]  hold_cnt, filt_cnt;
  logic [15:0] to_cnt;
  logic [4:0]  snap_obdiv, snap_ocdiv;
  logic        snap_bypassb, snap_bypassc;
  assign slock = sync[1];
  // lock only matters once the derived domains are running on a non-bypassed output
  assign lock_watch = state == IDLE && CLKRST_N && !(BYPASSB && BYPASSC) && !slock;
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state        <= HOLD;
      sync         <= 2'b00;
      low_prev     <= 1'b0;
      hold_cnt     <= 8'd0;
      filt_cnt     <= 8'd0;
      to_cnt       <= 16'd0;
      snap_obdiv   <= 5'b00011;
      snap_ocdiv   <= 5'b00011;
      snap_bypassb <= 1'b1;
      snap_bypassc <= 1'b1;
      OBDIV        <= 5'b00011;
      OCDIV        <= 5'b00011;
      BYPASSB      <= 1'b1;
      BYPASSC      <= 1'b1;
      CLKRST_N     <= 1'b0;
      CFG_ACK      <= 1'b0;
      BUSY         <= 1'b1;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      sync     <= {sync[0], CCC_LOCK};
      CFG_ACK  <= 1'b0;
      DONE     <= 1'b0;
      low_prev <= 1'b0;
      case (state)
        IDLE: begin
          if (CFG_REQ) begin
            snap_obdiv   <= CFG_OBDIV;
            snap_ocdiv   <= CFG_OCDIV;
            snap_bypassb <= CFG_BYPASSB;
            snap_bypassc <= CFG_BYPASSC;
            CFG_ACK      <= 1'b1;
            BUSY         <= 1'b1;
            CLKRST_N     <= 1'b0;
            hold_cnt     <= 8'd0;
            state        <= HOLD;
          end else if (lock_watch && low_prev) begin
            ERR      <= 1'b1;
            CLKRST_N <= 1'b0;
            BUSY     <= 1'b1;
            filt_cnt <= 8'd0;
            to_cnt   <= 16'd0;
            state    <= WAIT_LOCK;
          end else begin
            low_prev <= lock_watch;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= APPLY;
          else hold_cnt <= hold_cnt + {7'd0, hold_cnt != 8'hff};
        end
        APPLY: begin
          OBDIV    <= snap_obdiv;
          OCDIV    <= snap_ocdiv;
          BYPASSB  <= snap_bypassb;
          BYPASSC  <= snap_bypassc;
          filt_cnt <= 8'd0;
          to_cnt   <= 16'd0;
          state    <= (snap_bypassb && snap_bypassc) ? RELEASE : WAIT_LOCK;
        end
        WAIT_LOCK: begin
          filt_cnt <= slock ? filt_cnt + {7'd0, filt_cnt != 8'hff} : 8'd0;
          to_cnt   <= to_cnt + {15'd0, to_cnt != 16'hffff};
          if (slock && filt_cnt == FILT_LAST) begin
            state <= RELEASE;
          end else if (to_cnt == TO_LAST) begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        RELEASE: begin
          CLKRST_N <= 1'b1;
          DONE     <= 1'b1;
          ERR      <= 1'b0;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
